// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// FSM encoding, write-entry layout and regfile widths.
package rf_wport_arbiter_pkg;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 32;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_DRAIN  = 1'b1
   } arb_state_t;

   // 69-bit write entry {pc, addr, data}
   typedef struct packed {
      logic [PW-1:0] pc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Request-side bundle of the write-port arbiter:
// pipeline writeback stream and long-unit result stream.
interface rf_wport_arbiter_if;
   import rf_wport_arbiter_pkg::*;

   logic          wb_stall_i;
   logic          pipe_wen_i;
   logic [AW-1:0] pipe_waddr_i;
   logic [DW-1:0] pipe_wdata_i;
   logic [PW-1:0] pipe_pc_i;
   logic          lu_valid_i;
   logic [AW-1:0] lu_waddr_i;
   logic [DW-1:0] lu_wdata_i;
   logic [PW-1:0] lu_pc_i;
   logic          lu_ready_o;
   logic          pipe_stall_o;

   modport master (
      output wb_stall_i, pipe_wen_i, pipe_waddr_i,
      output pipe_wdata_i, pipe_pc_i,
      output lu_valid_i, lu_waddr_i, lu_wdata_i, lu_pc_i,
      input  lu_ready_o, pipe_stall_o
   );

   modport slave (
      input  wb_stall_i, pipe_wen_i, pipe_waddr_i,
      input  pipe_wdata_i, pipe_pc_i,
      input  lu_valid_i, lu_waddr_i, lu_wdata_i, lu_pc_i,
      output lu_ready_o, pipe_stall_o
   );

endinterface

// File: rtl/rf_wport_arbiter_fifo.sv
// wb_result_fifo: synchronous FIFO buffering long-unit results.
// Push and pop must be qualified by full/empty by the caller.
module wb_result_fifo
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int PTRW = $clog2(DEPTH);
   localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

   wb_entry_t       mem [DEPTH];
   logic [PTRW-1:0] wp;
   logic [PTRW-1:0] rp;
   logic [PTRW:0]   cnt;

   always_ff @(posedge clk)
      if (push) mem[wp] <= din;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign dout  = mem[rp];
   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipe writeback vs buffered long-unit.
// Optional WB_LU_BYPASS_EN lets an idle-cycle long-unit result skip the FIFO.
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   rf_wport_arbiter_if.slave   req,
   output logic                rf_wen_o,
   output logic [AW-1:0]       rf_waddr_o,
   output logic [DW-1:0]       rf_wdata_o,
   output logic [PW-1:0]       debug_wb_pc,
   output logic [3:0]          debug_wb_rf_wen,
   output logic [AW-1:0]       debug_wb_rf_wnum,
   output logic [DW-1:0]       debug_wb_rf_wdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_t    state;
   arb_state_t    state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;

   wb_entry_t pipe_e;
   wb_entry_t lu_e;
   wb_entry_t head;
   wb_entry_t wr;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic pipe_grant;
   logic byp;
   logic grant;

   assign pipe_e = '{pc:   req.pipe_pc_i,
                     addr: req.pipe_waddr_i,
                     data: req.pipe_wdata_i};
   assign lu_e   = '{pc:   req.lu_pc_i,
                     addr: req.lu_waddr_i,
                     data: req.lu_wdata_i};

   // readiness looks only at the registered count
   assign req.lu_ready_o = !full;
   assign push  = req.lu_valid_i && !full && !byp;
   assign grant = pipe_grant || pop || byp;

   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (lu_e),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ARB_NORMAL;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      pop        = 1'b0;
      pipe_grant = 1'b0;
      byp        = 1'b0;
      case (state)
         ARB_NORMAL: begin
            if (req.pipe_wen_i && !req.wb_stall_i) begin
               pipe_grant = 1'b1;
               cnt_nx     = empty ? '0 : cnt + 1'b1;
            end else if (!empty) begin
               pop    = 1'b1;
               cnt_nx = '0;
            end else begin
               cnt_nx = '0;
`ifdef WB_LU_BYPASS_EN
               byp    = req.lu_valid_i;
`endif
            end
            if (cnt_nx == LIMIT) state_nx = ARB_DRAIN;
         end
         ARB_DRAIN: begin
            pop      = !empty;
            cnt_nx   = '0;
            state_nx = ARB_NORMAL;
         end
         default: state_nx = ARB_NORMAL;
      endcase
   end

   always_comb begin
      req.pipe_stall_o = (state == ARB_DRAIN);
   end

   always_comb begin
      wr = head;
      unique case (1'b1)
         pipe_grant: wr = pipe_e;
         byp:        wr = lu_e;
         default:    wr = head;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_wen_o    <= 1'b0;
         rf_waddr_o  <= '0;
         rf_wdata_o  <= '0;
         debug_wb_pc <= '0;
      end else begin
         rf_wen_o <= grant && (wr.addr != REG_ZERO);
         if (grant) begin
            rf_waddr_o  <= wr.addr;
            rf_wdata_o  <= wr.data;
            debug_wb_pc <= wr.pc;
         end
      end
   end

   assign debug_wb_rf_wen   = {4{rf_wen_o}};
   assign debug_wb_rf_wnum  = rf_waddr_o;
   assign debug_wb_rf_wdata = rf_wdata_o;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios plus random traffic
// against a queue-based reference model; honours WB_LU_BYPASS_EN.
module tb_rf_wport_arbiter;
   import rf_wport_arbiter_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          rf_wen;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic [31:0]   dbg_pc;
   logic [3:0]    dbg_wen;
   logic [4:0]    dbg_wnum;
   logic [31:0]   dbg_wdata;

   rf_wport_arbiter_if bus ();

   rf_wport_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req               (bus),
      .rf_wen_o          (rf_wen),
      .rf_waddr_o        (rf_waddr),
      .rf_wdata_o        (rf_wdata),
      .debug_wb_pc       (dbg_pc),
      .debug_wb_rf_wen   (dbg_wen),
      .debug_wb_rf_wnum  (dbg_wnum),
      .debug_wb_rf_wdata (dbg_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   int          starve = 0;
   bit          drain  = 1'b0;
   logic        e_wen  = 1'b0;
   logic [4:0]  e_addr = '0;
   logic [31:0] e_data = '0;
   logic [31:0] e_pc   = '0;

   int vecs = 0;
   int errs = 0;

   logic        l_on = 1'b0;
   logic        l_wen;
   logic [4:0]  l_addr;
   logic [31:0] l_data;
   logic [31:0] l_pc;
   logic        l_ready;
   logic        l_stall;

   // reference: one write per edge, priority drain > pipe > fifo > bypass
   always @(posedge clk or negedge rst) begin : mdl
      ent_t w;
      bit   wv;
      bit   took;
      bit   room;
      if (!rst) begin
         q.delete();
         starve = 0;
         drain  = 1'b0;
         e_wen  = 1'b0;
         e_addr = '0;
         e_data = '0;
         e_pc   = '0;
      end else begin
         wv   = 1'b0;
         took = 1'b0;
         room = (q.size() < DEPTH);
         w    = '{pc: 0, a: 0, d: 0};
         if (drain) begin
            if (q.size() > 0) begin
               w  = q.pop_front();
               wv = 1'b1;
            end
            starve = 0;
            drain  = 1'b0;
         end else if (bus.pipe_wen_i && !bus.wb_stall_i) begin
            w  = '{pc: bus.pipe_pc_i, a: bus.pipe_waddr_i,
                   d: bus.pipe_wdata_i};
            wv = 1'b1;
            starve = (q.size() > 0) ? starve + 1 : 0;
            if (starve == LIMIT) drain = 1'b1;
         end else if (q.size() > 0) begin
            w  = q.pop_front();
            wv = 1'b1;
            starve = 0;
         end else begin
            starve = 0;
`ifdef WB_LU_BYPASS_EN
            if (bus.lu_valid_i) begin
               w    = '{pc: bus.lu_pc_i, a: bus.lu_waddr_i,
                        d: bus.lu_wdata_i};
               wv   = 1'b1;
               took = 1'b1;
            end
`endif
         end
         if (bus.lu_valid_i && room && !took)
            q.push_back('{pc: bus.lu_pc_i, a: bus.lu_waddr_i,
                          d: bus.lu_wdata_i});
         e_wen = wv && (w.a != 5'd0);
         if (wv) begin
            e_addr = w.a;
            e_data = w.d;
            e_pc   = w.pc;
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t",
                  n, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("rf_wen", 32'(rf_wen), 32'(e_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      chk("rf_wdata", rf_wdata, e_data);
      chk("wb_pc", dbg_pc, e_pc);
      chk("dbg_wen", 32'(dbg_wen), 32'({4{e_wen}}));
      chk("dbg_wnum", 32'(dbg_wnum), 32'(e_addr));
      chk("dbg_wdata", dbg_wdata, e_data);
      chk("lu_ready", 32'(bus.lu_ready_o), 32'(q.size() < DEPTH));
      chk("pipe_stall", 32'(bus.pipe_stall_o), 32'(drain));
      if (l_on) begin
         chk("pin_wen", 32'(rf_wen), 32'(l_wen));
         chk("pin_waddr", 32'(rf_waddr), 32'(l_addr));
         chk("pin_wdata", rf_wdata, l_data);
         chk("pin_pc", dbg_pc, l_pc);
         chk("pin_ready", 32'(bus.lu_ready_o), 32'(l_ready));
         chk("pin_stall", 32'(bus.pipe_stall_o), 32'(l_stall));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pipe_wen_i = 1'b0;
      bus.lu_valid_i = 1'b0;
      bus.wb_stall_i = 1'b0;
   endtask

   task automatic pipe(input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p);
      bus.pipe_wen_i   = 1'b1;
      bus.pipe_waddr_i = a;
      bus.pipe_wdata_i = d;
      bus.pipe_pc_i    = p;
   endtask

   task automatic lu(input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] p);
      bus.lu_valid_i = 1'b1;
      bus.lu_waddr_i = a;
      bus.lu_wdata_i = d;
      bus.lu_pc_i    = p;
   endtask

   task automatic pin(input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] p,
                      input logic r, input logic s);
      l_wen   = w;
      l_addr  = a;
      l_data  = d;
      l_pc    = p;
      l_ready = r;
      l_stall = s;
      l_on    = 1'b1;
      @(negedge clk);
      #1;
      l_on = 1'b0;
   endtask

   initial begin
      idle();
      bus.pipe_waddr_i = '0;
      bus.pipe_wdata_i = '0;
      bus.pipe_pc_i    = '0;
      bus.lu_waddr_i   = '0;
      bus.lu_wdata_i   = '0;
      bus.lu_pc_i      = '0;
      #2 rst = 1'b0;
      repeat (2) cyc();
      rst = 1'b1;
      repeat (10) cyc();
      pin(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

      pipe(5'd5, 32'hDEADBEEF, 32'hBFC00000);
      cyc();
      idle();
      pin(1'b1, 5'd5, 32'hDEADBEEF, 32'hBFC00000, 1'b1, 1'b0);

      lu(5'd3, 32'h12, 32'h100);
      cyc();
      idle();
`ifdef WB_LU_BYPASS_EN
      pin(1'b1, 5'd3, 32'h12, 32'h100, 1'b1, 1'b0);
`else
      pin(1'b0, 5'd5, 32'hDEADBEEF, 32'hBFC00000, 1'b1, 1'b0);
      cyc();
      pin(1'b1, 5'd3, 32'h12, 32'h100, 1'b1, 1'b0);
`endif
      repeat (2) cyc();

      pipe(5'd9, 32'h900, 32'h300);
      lu(5'd7, 32'h77, 32'h200);
      cyc();
      bus.lu_valid_i = 1'b0;
      repeat (4) cyc();
      pin(1'b1, 5'd9, 32'h900, 32'h300, 1'b1, 1'b1);
      cyc();
      pin(1'b1, 5'd7, 32'h77, 32'h200, 1'b1, 1'b0);
      cyc();
      pin(1'b1, 5'd9, 32'h900, 32'h300, 1'b1, 1'b0);
      idle();
      repeat (2) cyc();

      pipe(5'd10, 32'hA00, 32'h500);
      lu(5'd1, 32'hA1, 32'h400);
      cyc();
      lu(5'd2, 32'hB2, 32'h404);
      cyc();
      lu(5'd4, 32'hC4, 32'h408);
      cyc();
      pin(1'b1, 5'd10, 32'hA00, 32'h500, 1'b0, 1'b0);
      repeat (4) cyc();
      idle();
      cyc();
      pin(1'b1, 5'd2, 32'hB2, 32'h404, 1'b1, 1'b0);
      cyc();
      pin(1'b1, 5'd4, 32'hC4, 32'h408, 1'b1, 1'b0);
      repeat (2) cyc();

      pipe(5'd0, 32'h55, 32'h600);
      cyc();
      idle();
      pin(1'b0, 5'd0, 32'h55, 32'h600, 1'b1, 1'b0);

      pipe(5'd11, 32'hB00, 32'h700);
      lu(5'd12, 32'h12C, 32'h710);
      cyc();
      lu(5'd13, 32'h13D, 32'h714);
      cyc();
      idle();
      #2 rst = 1'b0;
      pin(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc();
      rst = 1'b1;
      repeat (3) cyc();
      pin(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         bus.pipe_wen_i   = ($urandom_range(9) < 6);
         bus.wb_stall_i   = ($urandom_range(4) == 0);
         bus.pipe_waddr_i = 5'($urandom);
         bus.pipe_wdata_i = $urandom;
         bus.pipe_pc_i    = $urandom;
         bus.lu_valid_i   = ($urandom_range(9) < 3);
         bus.lu_waddr_i   = 5'($urandom);
         bus.lu_wdata_i   = $urandom;
         bus.lu_pc_i      = $urandom;
         cyc();
      end
      idle();
      repeat (6) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
